// File: rtl/sap_ctrl_sequencer.sv
// sap_ctrl_sequencer: T-state sequencer and microcode decoder for the
// 8-bit shared-bus datapath. It steps a fetch/execute ring and decodes the
// control strobes from (tstate, opcode, cf, zf).
//
// Build option SEQ_EARLY_END_EN: when defined, each instruction returns to
// T0 right after its last active micro-step. When it is undefined, every
// instruction runs the full T0..T5 ring. The strobe content of each T-state
// is the same in both builds.
module sap_ctrl_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_en,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load_n,
    output logic       mar_load_n,
    output logic       ram_out,
    output logic       ram_we,
    output logic       ir_load_n,
    output logic       ir_out,
    output logic       a_load_n,
    output logic       a_out,
    output logic       b_load_n,
    output logic       alu_out,
    output logic       sub,
    output logic       out_load_n,
    output logic       halted,
    output logic [2:0] tstate
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstate_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    tstate_e tstate_q, tstate_d;
    logic    halted_q, halted_d;
    tstate_e last_step;

    // Last T-state of the current instruction; the counter wraps to T0 after it.
    always_comb begin
        last_step = T5;
`ifdef SEQ_EARLY_END_EN
        case (opcode)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase
`endif
    end

    // Next-state logic: advance, wrap or halt; freeze while halted or stepping is off.
    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (!halted_q && step_en) begin
            if (tstate_q == T2 && opcode == OP_HLT) begin
                // tstate stays parked at T2 once halted.
                halted_d = 1'b1;
            end else if (tstate_q >= last_step || tstate_q >= T5) begin
                tstate_d = T0;
            end else begin
                tstate_d = tstate_e'(tstate_q + 3'd1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tstate_q <= T0;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    // Strobe decode. Every strobe idles while in reset, halted or frozen.
    always_comb begin
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        pc_load_n  = 1'b1;
        mar_load_n = 1'b1;
        ram_out    = 1'b0;
        ram_we     = 1'b0;
        ir_load_n  = 1'b1;
        ir_out     = 1'b0;
        a_load_n   = 1'b1;
        a_out      = 1'b0;
        b_load_n   = 1'b1;
        alu_out    = 1'b0;
        sub        = 1'b0;
        out_load_n = 1'b1;
        if (!rst && !halted_q && step_en) begin
            case (tstate_q)
                T0: begin
                    pc_out     = 1'b1;
                    mar_load_n = 1'b0;
                end
                T1: begin
                    ram_out   = 1'b1;
                    ir_load_n = 1'b0;
                    pc_inc    = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out     = 1'b1;
                            mar_load_n = 1'b0;
                        end
                        OP_LDI: begin
                            ir_out   = 1'b1;
                            a_load_n = 1'b0;
                        end
                        OP_JMP: begin
                            ir_out    = 1'b1;
                            pc_load_n = 1'b0;
                        end
                        OP_JC: begin
                            if (cf) begin
                                ir_out    = 1'b1;
                                pc_load_n = 1'b0;
                            end
                        end
                        OP_JZ: begin
                            if (zf) begin
                                ir_out    = 1'b1;
                                pc_load_n = 1'b0;
                            end
                        end
                        OP_OUT: begin
                            a_out      = 1'b1;
                            out_load_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out  = 1'b1;
                            a_load_n = 1'b0;
                        end
                        OP_ADD: begin
                            ram_out  = 1'b1;
                            b_load_n = 1'b0;
                        end
                        OP_SUB: begin
                            ram_out  = 1'b1;
                            b_load_n = 1'b0;
                            sub      = 1'b1;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_we = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out  = 1'b1;
                        a_load_n = 1'b0;
                        sub      = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted = halted_q;
    assign tstate = tstate_q;

    // NOP is decoded through the default arms above.
    logic unused_nop;
    assign unused_nop = (opcode == OP_NOP);

endmodule

// File: tb/tb_sap_ctrl_sequencer.sv
// Directed testbench for sap_ctrl_sequencer. Works with either build of the
// SEQ_EARLY_END_EN option.
module tb_sap_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst, step_en, cf, zf;
    logic [3:0] opcode;
    logic       pc_out, pc_inc, pc_load_n, mar_load_n, ram_out, ram_we, ir_load_n;
    logic       ir_out, a_load_n, a_out, b_load_n, alu_out, sub, out_load_n, halted;
    logic [2:0] tstate;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef SEQ_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [13:0] M_PC_OUT  = 14'b10000000000000;
    localparam logic [13:0] M_PC_INC  = 14'b01000000000000;
    localparam logic [13:0] M_PC_LD   = 14'b00100000000000;
    localparam logic [13:0] M_MAR_LD  = 14'b00010000000000;
    localparam logic [13:0] M_RAM_OUT = 14'b00001000000000;
    localparam logic [13:0] M_RAM_WE  = 14'b00000100000000;
    localparam logic [13:0] M_IR_LD   = 14'b00000010000000;
    localparam logic [13:0] M_IR_OUT  = 14'b00000001000000;
    localparam logic [13:0] M_A_LD    = 14'b00000000100000;
    localparam logic [13:0] M_A_OUT   = 14'b00000000010000;
    localparam logic [13:0] M_B_LD    = 14'b00000000001000;
    localparam logic [13:0] M_ALU_OUT = 14'b00000000000100;
    localparam logic [13:0] M_SUB     = 14'b00000000000010;
    localparam logic [13:0] M_OUT_LD  = 14'b00000000000001;
    localparam logic [13:0] IDLE = M_PC_LD | M_MAR_LD | M_IR_LD | M_A_LD | M_B_LD | M_OUT_LD;
    localparam logic [13:0] W_T0 = IDLE ^ (M_PC_OUT | M_MAR_LD);
    localparam logic [13:0] W_T1 = IDLE ^ (M_RAM_OUT | M_IR_LD | M_PC_INC);

    logic [13:0] word;
    assign word = {pc_out, pc_inc, pc_load_n, mar_load_n, ram_out, ram_we, ir_load_n,
                   ir_out, a_load_n, a_out, b_load_n, alu_out, sub, out_load_n};

    sap_ctrl_sequencer dut (
        .clk(clk), .rst(rst), .step_en(step_en), .opcode(opcode), .cf(cf), .zf(zf),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load_n(pc_load_n), .mar_load_n(mar_load_n),
        .ram_out(ram_out), .ram_we(ram_we), .ir_load_n(ir_load_n), .ir_out(ir_out),
        .a_load_n(a_load_n), .a_out(a_out), .b_load_n(b_load_n), .alu_out(alu_out),
        .sub(sub), .out_load_n(out_load_n), .halted(halted), .tstate(tstate)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_t0(input string name);
        int n = 0;
        while (tstate !== 3'd0 && n < 8) begin
            tick();
            n++;
        end
        n_chk++;
        if (tstate !== 3'd0) $display("FAIL %s_wrap tstate=%0d expected=0", name, tstate);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; step_en = 1'b1; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
        tick(); tick();
        #1;
        n_chk++;
        if (word !== IDLE || tstate !== 3'd0 || halted !== 1'b0)
            $display("FAIL reset_hold word=%b ts=%0d h=%b expected word=%b ts=0 h=0", word, tstate, halted, IDLE);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++;
        if (word !== W_T0) $display("FAIL reset_t0 word=%b expected=%b", word, W_T0);
        else n_pass++;
        // Walk ADD into T3, then reset in the middle of it.
        opcode = 4'h2;
        tick(); tick(); tick();
        n_chk++;
        if (tstate !== 3'd3 || word !== (IDLE ^ (M_RAM_OUT | M_B_LD)))
            $display("FAIL reset_pre_t3 ts=%0d word=%b expected ts=3 word=%b", tstate, word, IDLE ^ (M_RAM_OUT | M_B_LD));
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if (word !== IDLE) $display("FAIL reset_mid_comb word=%b expected=%b", word, IDLE);
        else n_pass++;
        tick();
        n_chk++;
        if (word !== IDLE || tstate !== 3'd0) $display("FAIL reset_mid_c1 word=%b ts=%0d expected word=%b ts=0", word, tstate, IDLE);
        else n_pass++;
        tick();
        n_chk++;
        if (word !== IDLE || tstate !== 3'd0) $display("FAIL reset_mid_c2 word=%b ts=%0d expected word=%b ts=0", word, tstate, IDLE);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++;
        if (word !== W_T0 || tstate !== 3'd0) $display("FAIL reset_release word=%b ts=%0d expected word=%b ts=0", word, tstate, W_T0);
        else n_pass++;
    endtask

    task automatic test_add_sub();
        logic [13:0] exp_w;
        for (int s = 0; s < 2; s++) begin
            opcode = (s == 0) ? 4'h2 : 4'h3;
            #1;
            n_chk++;
            if (word !== W_T0) $display("FAIL alu%0d_t0 word=%b expected=%b", s, word, W_T0);
            else n_pass++;
            tick();
            n_chk++;
            if (word !== W_T1) $display("FAIL alu%0d_t1 word=%b expected=%b", s, word, W_T1);
            else n_pass++;
            tick();
            n_chk++;
            if (word !== (IDLE ^ (M_IR_OUT | M_MAR_LD))) $display("FAIL alu%0d_t2 word=%b expected=%b", s, word, IDLE ^ (M_IR_OUT | M_MAR_LD));
            else n_pass++;
            tick();
            exp_w = IDLE ^ (M_RAM_OUT | M_B_LD) ^ ((s == 1) ? M_SUB : 14'd0);
            n_chk++;
            if (word !== exp_w) $display("FAIL alu%0d_t3 word=%b expected=%b", s, word, exp_w);
            else n_pass++;
            tick();
            exp_w = IDLE ^ (M_ALU_OUT | M_A_LD) ^ ((s == 1) ? M_SUB : 14'd0);
            n_chk++;
            if (word !== exp_w || tstate !== 3'd4) $display("FAIL alu%0d_t4 word=%b ts=%0d expected word=%b ts=4", s, word, tstate, exp_w);
            else n_pass++;
            tick();
            exp_w = EARLY ? W_T0 : IDLE;
            n_chk++;
            if (tstate !== (EARLY ? 3'd0 : 3'd5) || word !== exp_w)
                $display("FAIL alu%0d_after_t4 ts=%0d word=%b expected ts=%0d word=%b", s, tstate, word, EARLY ? 0 : 5, exp_w);
            else n_pass++;
            to_t0("alu");
        end
    endtask

    task automatic test_cond_jumps();
        logic [13:0] exp_w;
        for (int j = 0; j < 4; j++) begin
            opcode = (j < 2) ? 4'h7 : 4'h8;
            // Drive the unused flag opposite to the tested one.
            if (j < 2) begin cf = (j == 0); zf = (j != 0); end
            else       begin zf = (j == 2); cf = (j != 2); end
            tick(); tick();
            exp_w = (j == 0 || j == 2) ? (IDLE ^ (M_IR_OUT | M_PC_LD)) : IDLE;
            n_chk++;
            if (word !== exp_w || tstate !== 3'd2) $display("FAIL jump%0d_t2 word=%b ts=%0d expected word=%b ts=2", j, word, tstate, exp_w);
            else n_pass++;
            tick();
            n_chk++;
            if (tstate !== (EARLY ? 3'd0 : 3'd3)) $display("FAIL jump%0d_next ts=%0d expected=%0d", j, tstate, EARLY ? 0 : 3);
            else n_pass++;
            to_t0("jump");
        end
        cf = 1'b0; zf = 1'b0;
    endtask

    task automatic test_misc_ops();
        logic [3:0]  ops [4] = '{4'h5, 4'h6, 4'hE, 4'h4};
        logic [13:0] exps [4];
        exps[0] = IDLE ^ (M_IR_OUT | M_A_LD);
        exps[1] = IDLE ^ (M_IR_OUT | M_PC_LD);
        exps[2] = IDLE ^ (M_A_OUT | M_OUT_LD);
        exps[3] = IDLE ^ (M_A_OUT | M_RAM_WE);
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            tick(); tick();
            if (k == 3) tick();
            n_chk++;
            if (word !== exps[k]) $display("FAIL op%h_exec word=%b expected=%b", ops[k], word, exps[k]);
            else n_pass++;
            to_t0("misc");
        end
    endtask

    task automatic test_freeze();
        opcode = 4'h1;
        tick();
        step_en = 1'b0;
        #1;
        n_chk++;
        if (word !== IDLE || tstate !== 3'd1) $display("FAIL freeze_enter word=%b ts=%0d expected word=%b ts=1", word, tstate, IDLE);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (word !== IDLE || tstate !== 3'd1 || ir_load_n !== 1'b1 || pc_inc !== 1'b0)
                $display("FAIL freeze_c%0d word=%b ts=%0d expected word=%b ts=1", i, word, tstate, IDLE);
            else n_pass++;
        end
        step_en = 1'b1;
        #1;
        n_chk++;
        if (word !== W_T1 || tstate !== 3'd1) $display("FAIL freeze_resume word=%b ts=%0d expected word=%b ts=1", word, tstate, W_T1);
        else n_pass++;
        tick(); tick();
        n_chk++;
        if (word !== (IDLE ^ (M_RAM_OUT | M_A_LD))) $display("FAIL lda_t3 word=%b expected=%b", word, IDLE ^ (M_RAM_OUT | M_A_LD));
        else n_pass++;
        tick();
        n_chk++;
        if (tstate !== (EARLY ? 3'd0 : 3'd4)) $display("FAIL lda_next ts=%0d expected=%0d", tstate, EARLY ? 0 : 4);
        else n_pass++;
        to_t0("lda");
    endtask

    task automatic test_halt();
        opcode = 4'hF;
        tick(); tick();
        n_chk++;
        if (word !== IDLE || halted !== 1'b0 || tstate !== 3'd2) $display("FAIL hlt_t2 word=%b h=%b ts=%0d expected word=%b h=0 ts=2", word, halted, tstate, IDLE);
        else n_pass++;
        tick();
        for (int i = 0; i < 10; i++) begin
            step_en = i[0];
            opcode = 4'h2;
            #1;
            n_chk++;
            if (word !== IDLE || halted !== 1'b1 || tstate !== 3'd2)
                $display("FAIL halt_c%0d word=%b h=%b ts=%0d expected word=%b h=1 ts=2", i, word, halted, tstate, IDLE);
            else n_pass++;
            tick();
        end
        step_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_chk++;
        if (halted !== 1'b0 || tstate !== 3'd0 || word !== W_T0) $display("FAIL halt_clear h=%b ts=%0d word=%b expected h=0 ts=0 word=%b", halted, tstate, word, W_T0);
        else n_pass++;
    endtask

    task automatic test_bus_excl();
        int bad = 0;
        for (int op = 0; op < 16; op++) begin
            for (int f = 0; f < 4; f++) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                opcode = op[3:0];
                cf = f[0];
                zf = f[1];
                for (int c = 0; c < 6; c++) begin
                    #1;
                    n_chk++;
                    if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
                        $display("FAIL bus_excl op=%h f=%0d ts=%0d drivers=%b expected at most one", op, f, tstate,
                                 {pc_out, ram_out, ir_out, a_out, alu_out});
                        bad++;
                    end else n_pass++;
                    tick();
                end
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cf = 1'b0; zf = 1'b0; opcode = 4'h0;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_cond_jumps();
        test_misc_ops();
        test_freeze();
        test_halt();
        test_bus_excl();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
